// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op codes, FSM states and op decode helpers.
package lsu_pkg;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LH  = 4'd1;
  localparam logic [3:0] OP_LW  = 4'd2;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RMW_RD,
    ST_WRITE,
    ST_RESP
  } lsu_state_e;

  function automatic logic is_store(input logic [3:0] op);
    return op[3];
  endfunction

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // size: 0 byte, 1 halfword, 2 word (op[1:0])
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return (size == 2'd1 && lo[0]) || (size == 2'd2 && lo != 2'b00);
  endfunction

  // Byte lane actually used; misaligned low bits are dropped when errors are disabled.
  function automatic logic [1:0] lane_of(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'd0:    return lo;
      2'd1:    return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: load extraction with sign/zero extension and sub-word store merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = word[{lane, 3'b000} +: 8];
    half_sel  = lane[1] ? word[31:16] : word[15:0];
    load_data = word;
    merged    = wdata;
    case (size)
      2'd0: begin
        load_data = uns ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        merged    = word;
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      2'd1: begin
        load_data = uns ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
        merged    = lane[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
      end
      default: begin
        load_data = word;
        merged    = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one request at a time, sub-word stores done as read-modify-write.
// state     | meaning
// IDLE      | ready for a request
// LOAD      | memory read of the word holding the load data
// RMW_RD    | read of the old word before a byte/half store
// WRITE     | write strobe held over the memory's falling-edge sample
// RESP      | one-cycle response pulse
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e  state;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic [31:0] load_data;
  logic [31:0] merged;
  logic        req_bad;

  assign req_bad = !op_legal(req_op) ||
                   (ERR_ON_MISALIGN && is_misaligned(req_op[1:0], req_addr[1:0]));

  lsu_lane_align u_align (
    .size      (size_q),
    .uns       (uns_q),
    .lane      (lane_q),
    .word      (mem_rdata),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_ren    <= 1'b0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      lane_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            size_q    <= req_op[1:0];
            uns_q     <= req_op[2];
            lane_q    <= lane_of(req_op[1:0], req_addr[1:0]);
            wdata_q   <= req_wdata;
            if (req_bad) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
              if (!is_store(req_op)) begin
                state   <= ST_LOAD;
                mem_ren <= 1'b1;
              end else if (req_op == OP_SW) begin
                state     <= ST_WRITE;
                mem_wen   <= 1'b1;
                mem_wdata <= req_wdata;
              end else begin
                state   <= ST_RMW_RD;
                mem_ren <= 1'b1;
              end
            end
          end
        end
        ST_LOAD: begin
          state      <= ST_RESP;
          mem_ren    <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= load_data;
        end
        ST_RMW_RD: begin
          state     <= ST_WRITE;
          mem_ren   <= 1'b0;
          mem_wen   <= 1'b1;
          mem_wdata <= merged;
        end
        ST_WRITE: begin
          state      <= ST_RESP;
          mem_wen    <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        ST_RESP: begin
          state      <= ST_IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a falling-edge-write word memory and a byte-level reference model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail = 0;
  int acc_cnt = 0;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];

  load_store_unit #(.ADDR_W(32), .ERR_ON_MISALIGN(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_ren    (mem_ren),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];
  always @(negedge clk) if (mem_wen) mem[mem_addr[7:2]] <= mem_wdata;
  always @(posedge clk) if (rst_n && req_valid && req_ready) acc_cnt++;

  // Reference: byte-addressed semantics computed with plain arithmetic on ref_mem.
  function automatic void model(input logic [3:0] op, input logic [7:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er, output int lat, output int nwr);
    int nbytes, sh, idx;
    bit sgn, st, legal;
    logic [63:0] mask, v;
    legal = 1; sgn = 0; st = 0; nbytes = 4;
    case (op)
      OP_LB:   begin nbytes = 1; sgn = 1; end
      OP_LBU:  nbytes = 1;
      OP_LH:   begin nbytes = 2; sgn = 1; end
      OP_LHU:  nbytes = 2;
      OP_LW:   nbytes = 4;
      OP_SB:   begin nbytes = 1; st = 1; end
      OP_SH:   begin nbytes = 2; st = 1; end
      OP_SW:   begin nbytes = 4; st = 1; end
      default: legal = 0;
    endcase
    rd = 0; er = 0; nwr = 0; lat = 1;
    if (!legal || (int'(a) % nbytes) != 0) begin
      er = 1;
      return;
    end
    idx  = int'(a) / 4;
    sh   = (int'(a) % 4) * 8;
    mask = (64'd1 << (8 * nbytes)) - 64'd1;
    if (st) begin
      v = {32'd0, ref_mem[idx]};
      v = (v & ~(mask << sh)) | (({32'd0, wd} & mask) << sh);
      ref_mem[idx] = v[31:0];
      lat = (nbytes == 4) ? 2 : 3;
      nwr = 1;
    end else begin
      v = ({32'd0, ref_mem[idx]} >> sh) & mask;
      if (sgn && v[8 * nbytes - 1]) v = v | ~mask;
      rd  = v[31:0];
      lat = 2;
    end
  endfunction

  // Issues one request and observes it at falling edges until the response (bounded).
  // busy counts req_ready seen while busy plus 100 per cycle with ren and wen both high.
  task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input bit keep, output logic [31:0] rd, output logic er, output int lat,
                        output int nrd, output int nwr, output logic [31:0] wr_word,
                        output logic [31:0] wr_addr, output int busy);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
    lat = 0; nrd = 0; nwr = 0; busy = 0; rd = 'x; er = 1'bx; wr_word = '0; wr_addr = '0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (mem_ren) nrd++;
      if (mem_wen) begin nwr++; wr_word = mem_wdata; wr_addr = mem_addr; end
      if (mem_ren && mem_wen) busy += 100;
      if (req_ready) busy++;
      if (resp_valid) begin
        rd = resp_rdata;
        er = resp_err;
        break;
      end
    end
    if (!resp_valid) lat = 99;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({req_ready, resp_valid, resp_err, mem_ren, mem_wen} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 10000", {req_ready, resp_valid, resp_err, mem_ren, mem_wen});
    end
    n_checks++;
    if ({resp_rdata, mem_addr, mem_wdata} !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_data rdata=%h addr=%h wdata=%h want 0", resp_rdata, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release ready=%b valid=%b want 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_sw_lw();
    logic [31:0] rd, ww, wa; logic er; int lat, nrd, nwr, busy;
    do_req(OP_SW, 32'h10, 32'hDEADBEEF, 0, rd, er, lat, nrd, nwr, ww, wa, busy);
    n_checks++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'd0 || busy !== 0) begin
      n_fail++;
      $display("FAIL sw_resp lat=%0d err=%b rdata=%h busy=%0d want 2 0 0 0", lat, er, rd, busy);
    end
    n_checks++;
    if (nwr !== 1 || nrd !== 0 || ww !== 32'hDEADBEEF || wa !== 32'h10 || mem[4] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL sw_write nwr=%0d nrd=%0d wdata=%h addr=%h mem=%h want 1 0 deadbeef 10 deadbeef",
               nwr, nrd, ww, wa, mem[4]);
    end
    do_req(OP_LW, 32'h10, 32'h0, 0, rd, er, lat, nrd, nwr, ww, wa, busy);
    n_checks++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEADBEEF || nrd !== 1 || nwr !== 0 || busy !== 0) begin
      n_fail++;
      $display("FAIL lw_resp lat=%0d err=%b rdata=%h nrd=%0d nwr=%0d busy=%0d want 2 0 deadbeef 1 0 0",
               lat, er, rd, nrd, nwr, busy);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (resp_rdata !== 32'hDEADBEEF || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rdata_hold got %h valid=%b want deadbeef 0", resp_rdata, resp_valid);
    end
  endtask

  task automatic test_sb_rmw();
    logic [31:0] rd, ww, wa; logic er; int lat, nrd, nwr, busy;
    do_req(OP_SB, 32'h11, 32'h77777755, 0, rd, er, lat, nrd, nwr, ww, wa, busy);
    n_checks++;
    if (lat !== 3 || er !== 1'b0 || rd !== 32'd0 || nrd !== 1 || nwr !== 1 || busy !== 0) begin
      n_fail++;
      $display("FAIL sb_resp lat=%0d err=%b rdata=%h nrd=%0d nwr=%0d busy=%0d want 3 0 0 1 1 0",
               lat, er, rd, nrd, nwr, busy);
    end
    n_checks++;
    if (ww !== 32'hDEAD55EF || wa !== 32'h10 || mem[4] !== 32'hDEAD55EF) begin
      n_fail++;
      $display("FAIL sb_merge wdata=%h addr=%h mem=%h want dead55ef 10 dead55ef", ww, wa, mem[4]);
    end
  endtask

  task automatic test_load_ext();
    logic [31:0] rd, ww, wa; logic er; int lat, nrd, nwr, busy;
    logic [3:0]  ops  [4] = '{OP_LB, OP_LBU, OP_LH, OP_LHU};
    logic [31:0] adrs [4] = '{32'h20, 32'h20, 32'h22, 32'h22};
    logic [31:0] exps [4] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF8001, 32'h00008001};
    @(negedge clk);
    mem[8] = 32'h8001F0FF;
    for (int i = 0; i < 4; i++) begin
      do_req(ops[i], adrs[i], 32'h0, 0, rd, er, lat, nrd, nwr, ww, wa, busy);
      n_checks++;
      if (rd !== exps[i] || er !== 1'b0 || lat !== 2 || busy !== 0) begin
        n_fail++;
        $display("FAIL load_ext[%0d] rdata=%h err=%b lat=%0d busy=%0d want %h 0 2 0",
                 i, rd, er, lat, busy, exps[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, ww, wa; logic er; int lat, nrd, nwr, busy;
    logic [3:0]  ops  [3] = '{OP_LW, OP_SH, 4'hF};
    logic [31:0] adrs [3] = '{32'h13, 32'h21, 32'h20};
    for (int i = 0; i < 3; i++) begin
      do_req(ops[i], adrs[i], 32'h12345678, 0, rd, er, lat, nrd, nwr, ww, wa, busy);
      n_checks++;
      if (er !== 1'b1 || rd !== 32'd0 || lat !== 1 || nrd !== 0 || nwr !== 0 || busy !== 0) begin
        n_fail++;
        $display("FAIL err_resp[%0d] err=%b rdata=%h lat=%0d nrd=%0d nwr=%0d busy=%0d want 1 0 1 0 0 0",
                 i, er, rd, lat, nrd, nwr, busy);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd, ww, wa; logic er; int lat, nrd, nwr, busy;
    @(negedge clk);
    mem[12] = 32'h11111111;
    req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n_checks++;
    if (mem_wen !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_setup mem_wen=%b want 1", mem_wen);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_wen, mem_ren, req_ready, resp_valid, resp_err} !== 5'b00100 ||
        mem_addr !== 32'd0 || mem_wdata !== 32'd0 || resp_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL abort_outputs ctrl=%b addr=%h wdata=%h rdata=%h want 00100 0 0 0",
               {mem_wen, mem_ren, req_ready, resp_valid, resp_err}, mem_addr, mem_wdata, resp_rdata);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (mem[12] !== 32'h11111111) begin
      n_fail++;
      $display("FAIL abort_mem got %h want 11111111", mem[12]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_req(OP_LW, 32'h30, 32'h0, 0, rd, er, lat, nrd, nwr, ww, wa, busy);
    n_checks++;
    if (rd !== 32'h11111111 || er !== 1'b0 || lat !== 2 || busy !== 0) begin
      n_fail++;
      $display("FAIL abort_recover rdata=%h err=%b lat=%0d busy=%0d want 11111111 0 2 0", rd, er, lat, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, ww, wa; logic er; int lat, nrd, nwr, busy, acc0;
    logic [3:0]  ops  [4] = '{OP_SW, OP_LW, OP_SB, OP_LHU};
    logic [31:0] adrs [4] = '{32'h40, 32'h40, 32'h43, 32'h42};
    logic [31:0] wds  [4] = '{32'hA5A5A5A5, 32'h0, 32'h00000012, 32'h0};
    logic [31:0] exps [4] = '{32'h0, 32'hA5A5A5A5, 32'h0, 32'h000012A5};
    int          lats [4] = '{2, 2, 3, 2};
    acc0 = acc_cnt;
    for (int i = 0; i < 4; i++) begin
      do_req(ops[i], adrs[i], wds[i], 1, rd, er, lat, nrd, nwr, ww, wa, busy);
      n_checks++;
      if (rd !== exps[i] || er !== 1'b0 || lat !== lats[i] || busy !== 0) begin
        n_fail++;
        $display("FAIL b2b[%0d] rdata=%h err=%b lat=%0d busy=%0d want %h 0 %0d 0",
                 i, rd, er, lat, busy, exps[i], lats[i]);
      end
    end
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (acc_cnt - acc0 !== 4 || mem[16] !== 32'h12A5A5A5) begin
      n_fail++;
      $display("FAIL b2b_accepts count=%0d mem=%h want 4 12a5a5a5", acc_cnt - acc0, mem[16]);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, ww, wa, exp_rd, wd; logic er, exp_er; logic [3:0] op; logic [7:0] a;
    int lat, nrd, nwr, busy, exp_lat, exp_nwr;
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
    for (int i = 0; i < 200; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 8'($urandom_range(0, 255));
      wd = $urandom;
      model(op, a, wd, exp_rd, exp_er, exp_lat, exp_nwr);
      do_req(op, {24'd0, a}, wd, 0, rd, er, lat, nrd, nwr, ww, wa, busy);
      n_checks++;
      if (rd !== exp_rd || er !== exp_er || lat !== exp_lat || nwr !== exp_nwr || busy !== 0) begin
        n_fail++;
        $display("FAIL rand[%0d] op=%h addr=%h rdata=%h err=%b lat=%0d nwr=%0d busy=%0d want %h %b %0d %0d 0",
                 i, op, a, rd, er, lat, nwr, busy, exp_rd, exp_er, exp_lat, exp_nwr);
      end
      n_checks++;
      if (mem[a[7:2]] !== ref_mem[a[7:2]]) begin
        n_fail++;
        $display("FAIL rand_mem[%0d] word %0d got %h want %h", i, a[7:2], mem[a[7:2]], ref_mem[a[7:2]]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    test_reset();
    test_sw_lw();
    test_sb_rmw();
    test_load_ext();
    test_errors();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
